sxr_phase_enable_gen: RTL

//  Parametrised multi-phase timing generator for the sxrRISC core.

---
 rtl/sxr_phase_enable_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sxr_phase_enable_gen.sv
// Multi-phase one-hot clock-enable generator for the sxrRISC sequencer: lock delay, free-run/single-step/halt.
// Latency: phase_en[0] one refclk after the IDLE->RUN decision; no backpressure, mode honoured only at cycle boundaries.
module sxr_phase_enable_gen #(
  parameter int NUM_PHASES  = 3,
  parameter int DIV_W       = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          refclk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic                          step,
  input  logic [DIV_W-1:0]              div_ratio,
  output logic [NUM_PHASES-1:0]         phase_en,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          cycle_done,
  output logic                          running,
  output logic                          locked
);

  localparam int PH_W = $clog2(NUM_PHASES);
  localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [LK_W-1:0]  LAST_LK = LK_W'(LOCK_CYCLES - 1);
  localparam logic [LK_W-1:0]  LK_ONE  = LK_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [1:0]       MODE_FREE = 2'b00;
  localparam logic [1:0]       MODE_STEP = 2'b01;

  typedef enum logic [1:0] {
    ST_LOCK = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [LK_W-1:0]       lock_cnt_q, lock_cnt_n;
  logic [DIV_W-1:0]      div_q, div_n;
  logic [DIV_W-1:0]      divcnt_q, divcnt_n;
  logic [DIV_W-1:0]      div_eff;
  logic [PH_W-1:0]       phase_q, phase_n;
  logic                  one_shot_q, one_shot_n;
  logic                  locked_n;
  logic [NUM_PHASES-1:0] phase_en_n;
  logic                  cycle_done_n;

  assign div_eff = (div_ratio == '0) ? DIV_ONE : div_ratio;

  always_comb begin
    state_n    = state_q;
    lock_cnt_n = lock_cnt_q;
    div_n      = div_q;
    divcnt_n   = divcnt_q;
    phase_n    = phase_q;
    one_shot_n = one_shot_q;
    locked_n   = locked;

    case (state_q)
      ST_LOCK: begin
        if (lock_cnt_q == LAST_LK) begin
          locked_n = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          lock_cnt_n = lock_cnt_q + LK_ONE;
        end
      end

      ST_IDLE: begin
        if ((mode == MODE_FREE) || ((mode == MODE_STEP) && step)) begin
          state_n    = ST_RUN;
          one_shot_n = (mode == MODE_STEP);
          div_n      = div_eff;
          divcnt_n   = '0;
          phase_n    = '0;
        end
      end

      ST_RUN: begin
        if (divcnt_q == (div_q - DIV_ONE)) begin
          divcnt_n = '0;
          if (phase_q == LAST_PH) begin
            phase_n = '0;
            // Only an uninterrupted free-run continues; every other case parks in IDLE.
            if ((mode == MODE_FREE) && !one_shot_q) begin
              div_n = div_eff;
            end else begin
              state_n    = ST_IDLE;
              one_shot_n = 1'b0;
            end
          end else begin
            phase_n = phase_q + PH_ONE;
          end
        end else begin
          divcnt_n = divcnt_q + DIV_ONE;
        end
      end

      default: state_n = ST_LOCK;
    endcase
  end

  // Strobes are flopped from next-state values so they line up with the phase they mark.
  always_comb begin
    phase_en_n   = '0;
    cycle_done_n = 1'b0;
    if (state_n == ST_RUN) begin
      if (divcnt_n == '0) begin
        phase_en_n = {{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_n;
      end
      cycle_done_n = (phase_n == LAST_PH) && (divcnt_n == (div_n - DIV_ONE));
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOCK;
      lock_cnt_q <= '0;
      div_q      <= '0;
      divcnt_q   <= '0;
      phase_q    <= '0;
      one_shot_q <= 1'b0;
      locked     <= 1'b0;
      phase_en   <= '0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      lock_cnt_q <= lock_cnt_n;
      div_q      <= div_n;
      divcnt_q   <= divcnt_n;
      phase_q    <= phase_n;
      one_shot_q <= one_shot_n;
      locked     <= locked_n;
      phase_en   <= phase_en_n;
      cycle_done <= cycle_done_n;
    end
  end

  assign running   = (state_q == ST_RUN);
  assign phase_idx = running ? phase_q : '0;

endmodule
